// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: init-sequencer states, command encodings and
// default JEDEC timing values reused by the SDRAM command path.
package sdram_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_PWRUP    = 4'd1,
        ST_PRE      = 4'd2,
        ST_WAIT_RP  = 4'd3,
        ST_REF      = 4'd4,
        ST_WAIT_RFC = 4'd5,
        ST_LMR      = 4'd6,
        ST_WAIT_MRD = 4'd7,
        ST_DONE     = 4'd8
    } sdram_init_state_t;

    // Commands as {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_INHIBIT = 4'b1111;
    localparam logic [3:0] CMD_NOP     = 4'b0111;
    localparam logic [3:0] CMD_PRE     = 4'b0010;
    localparam logic [3:0] CMD_REF     = 4'b0001;
    localparam logic [3:0] CMD_LMR     = 4'b0000;

    // Default timing at 100 MHz
    localparam int          DEF_PWRUP_WAIT_CYCLES = 20000;
    localparam int          DEF_T_RP              = 2;
    localparam int          DEF_T_RFC             = 7;
    localparam int          DEF_T_MRD             = 2;
    localparam int          DEF_REFRESH_COUNT     = 8;
    localparam logic [12:0] DEF_MODE_REG          = 13'h0032;

    // Largest of four wait values; sizes the shared down-counter
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sdram_rst_sync.sv
// Two-flop synchronizer for the generator's controller hold-off, cleared
// asynchronously by the block reset so a restart never leaks through.
module sdram_rst_sync (
    input  logic i_clk,
    input  logic i_clr,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/sdram_init_seq.sv
// SDRAM power-up init sequencer: CKE rise, power-up wait, PRECHARGE ALL,
// N x AUTO REFRESH, LOAD MODE, then calc_done back to the reset generator.
// Outputs are decoded from the next state and registered, so every pin
// changes on the same edge as the state it belongs to.
module sdram_init_seq
    import sdram_pkg::*;
#(
    parameter int                    ADDR_WIDTH        = 13,
    parameter int                    BA_WIDTH          = 2,
    parameter int                    PWRUP_WAIT_CYCLES = 20000,
    parameter int                    T_RP              = 2,
    parameter int                    T_RFC             = 7,
    parameter int                    T_MRD             = 2,
    parameter int                    REFRESH_COUNT     = 8,
    parameter logic [ADDR_WIDTH-1:0] MODE_REG          = 13'h0032
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  rst_ddr_n,
    output logic                  calc_done,
    output logic                  sdram_cke,
    output logic                  sdram_cs_n,
    output logic                  sdram_ras_n,
    output logic                  sdram_cas_n,
    output logic                  sdram_we_n,
    output logic [BA_WIDTH-1:0]   sdram_ba,
    output logic [ADDR_WIDTH-1:0] sdram_addr
);

    localparam int MAX_WAIT = max4(PWRUP_WAIT_CYCLES, T_RP, T_RFC, T_MRD);
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);
    localparam int REF_W    = $clog2(REFRESH_COUNT + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    // Wait states last (T - 1) cycles: the command cycle itself counts as one
    localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(PWRUP_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_RP    = (T_RP  > 1) ? CNT_W'(T_RP  - 2) : CNT_ZERO;
    localparam logic [CNT_W-1:0] LD_RFC   = (T_RFC > 1) ? CNT_W'(T_RFC - 2) : CNT_ZERO;
    localparam logic [CNT_W-1:0] LD_MRD   = (T_MRD > 1) ? CNT_W'(T_MRD - 2) : CNT_ZERO;

    localparam logic [REF_W:0]   REF_TOTAL = (REF_W + 1)'(REFRESH_COUNT);
    localparam logic [REF_W:0]   REF_ONE   = (REF_W + 1)'(32'd1);
    localparam logic [REF_W-1:0] REF_ZERO  = {REF_W{1'b0}};

    // PRECHARGE ALL is selected by A10
    localparam logic [ADDR_WIDTH-1:0] PRE_ADDR  = ADDR_WIDTH'(32'd1024);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [BA_WIDTH-1:0]   BA_ZERO   = {BA_WIDTH{1'b0}};

    logic                  w_rst_ddr_n_s;
    sdram_init_state_t     r_state;
    sdram_init_state_t     w_next_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [REF_W-1:0]      r_ref_cnt;
    logic [REF_W:0]        w_ref_inc;
    logic                  w_cke;
    logic [3:0]            w_cmd;
    logic [BA_WIDTH-1:0]   w_ba;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_done;
    logic                  r_cke;
    logic [3:0]            r_cmd;
    logic [BA_WIDTH-1:0]   r_ba;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_done;

    sdram_rst_sync u_rst_sync (
        .i_clk (sys_clk),
        .i_clr (sys_rst),
        .i_d   (rst_ddr_n),
        .o_q   (w_rst_ddr_n_s)
    );

    assign w_ref_inc = {1'b0, r_ref_cnt} + REF_ONE;

    // State register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; a low hold-off always returns to IDLE for a full restart
    always_comb begin
        w_next_state = r_state;
        if (!w_rst_ddr_n_s) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:     w_next_state = ST_PWRUP;
                ST_PWRUP: begin
                    if (r_cnt == CNT_ZERO) w_next_state = ST_PRE;
                    else                   w_next_state = ST_PWRUP;
                end
                ST_PRE: begin
                    if (T_RP > 1) w_next_state = ST_WAIT_RP;
                    else          w_next_state = ST_REF;
                end
                ST_WAIT_RP: begin
                    if (r_cnt == CNT_ZERO) w_next_state = ST_REF;
                    else                   w_next_state = ST_WAIT_RP;
                end
                ST_REF: begin
                    if (T_RFC > 1)                   w_next_state = ST_WAIT_RFC;
                    else if (w_ref_inc < REF_TOTAL)  w_next_state = ST_REF;
                    else                             w_next_state = ST_LMR;
                end
                ST_WAIT_RFC: begin
                    if (r_cnt != CNT_ZERO)                    w_next_state = ST_WAIT_RFC;
                    else if ({1'b0, r_ref_cnt} < REF_TOTAL)   w_next_state = ST_REF;
                    else                                      w_next_state = ST_LMR;
                end
                ST_LMR: begin
                    if (T_MRD > 1) w_next_state = ST_WAIT_MRD;
                    else           w_next_state = ST_DONE;
                end
                ST_WAIT_MRD: begin
                    if (r_cnt == CNT_ZERO) w_next_state = ST_DONE;
                    else                   w_next_state = ST_WAIT_MRD;
                end
                ST_DONE:     w_next_state = ST_DONE;
                default:     w_next_state = ST_IDLE;
            endcase
        end
    end

    // Shared wait counter: loaded on entry to a timed state, counts down to zero
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_cnt <= CNT_ZERO;
        end else if (!w_rst_ddr_n_s) begin
            r_cnt <= CNT_ZERO;
        end else if (w_next_state != r_state) begin
            case (w_next_state)
                ST_PWRUP:    r_cnt <= LD_PWRUP;
                ST_WAIT_RP:  r_cnt <= LD_RP;
                ST_WAIT_RFC: r_cnt <= LD_RFC;
                ST_WAIT_MRD: r_cnt <= LD_MRD;
                default:     r_cnt <= CNT_ZERO;
            endcase
        end else if (r_cnt != CNT_ZERO) begin
            r_cnt <= r_cnt - CNT_ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Refresh counter: cleared entering PRECHARGE, bumped on each REFRESH cycle, saturating
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_ref_cnt <= REF_ZERO;
        end else if (!w_rst_ddr_n_s) begin
            r_ref_cnt <= REF_ZERO;
        end else if (w_next_state == ST_PRE) begin
            r_ref_cnt <= REF_ZERO;
        end else if ((r_state == ST_REF) && (w_ref_inc <= REF_TOTAL)) begin
            r_ref_cnt <= w_ref_inc[REF_W-1:0];
        end else begin
            r_ref_cnt <= r_ref_cnt;
        end
    end

    // Pin values for the state being entered
    always_comb begin
        w_cke  = 1'b1;
        w_cmd  = CMD_NOP;
        w_ba   = BA_ZERO;
        w_addr = ADDR_ZERO;
        w_done = 1'b0;
        case (w_next_state)
            ST_IDLE: begin
                w_cke = 1'b0;
                w_cmd = CMD_INHIBIT;
            end
            ST_PRE: begin
                w_cmd  = CMD_PRE;
                w_addr = PRE_ADDR;
            end
            ST_REF: begin
                w_cmd = CMD_REF;
            end
            ST_LMR: begin
                w_cmd  = CMD_LMR;
                w_addr = MODE_REG;
            end
            ST_DONE: begin
                w_done = 1'b1;
            end
            default: begin
                w_cmd = CMD_NOP;
            end
        endcase
    end

    // Output registers: pins come straight from flops
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_cke  <= 1'b0;
            r_cmd  <= CMD_INHIBIT;
            r_ba   <= BA_ZERO;
            r_addr <= ADDR_ZERO;
            r_done <= 1'b0;
        end else begin
            r_cke  <= w_cke;
            r_cmd  <= w_cmd;
            r_ba   <= w_ba;
            r_addr <= w_addr;
            r_done <= w_done;
        end
    end

    assign calc_done = r_done;
    assign sdram_cke = r_cke;
    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = r_cmd;
    assign sdram_ba   = r_ba;
    assign sdram_addr = r_addr;

endmodule

// File: tb/tb_sdram_init_seq.sv
// Bench for sdram_init_seq: a timeline model predicts the pins every cycle,
// a monitor compares at the falling edge; a second default-parameter
// instance checks the full-length power-up sequence.
module tb_sdram_init_seq;

    localparam int TW   = 10;
    localparam int TRP  = 2;
    localparam int TRFC = 7;
    localparam int TMRD = 2;
    localparam int TR   = 2;
    localparam logic [12:0] TMODE = 13'h0032;

    localparam logic [3:0] C_INH = 4'b1111;
    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_LMR = 4'b0000;

    typedef struct packed {
        logic       cke;
        logic [3:0] cmd;
        logic       done;
        logic       chk_pre;
        logic       chk_lmr;
        logic       chk_zero;
    } exp_t;

    logic        sys_clk;
    logic        sys_rst;
    logic        rst_ddr_n;
    logic        calc_done;
    logic        cke, cs_n, ras_n, cas_n, we_n;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic [3:0]  cmd;

    logic        sys_rst2;
    logic        rst_ddr_n2;
    logic        done2, cke2, cs2, ras2, cas2, we2;
    logic [1:0]  ba2;
    logic [12:0] addr2;
    logic [3:0]  cmd2;

    int   vectors;
    int   miscompares;
    exp_t exp_q[$];
    logic m_s1, m_s2;
    int   m_run;

    assign cmd  = {cs_n, ras_n, cas_n, we_n};
    assign cmd2 = {cs2, ras2, cas2, we2};

    sdram_init_seq #(
        .PWRUP_WAIT_CYCLES (TW), .T_RP (TRP), .T_RFC (TRFC),
        .T_MRD (TMRD), .REFRESH_COUNT (TR), .MODE_REG (TMODE)
    ) u_dut (
        .sys_clk (sys_clk), .sys_rst (sys_rst), .rst_ddr_n (rst_ddr_n),
        .calc_done (calc_done), .sdram_cke (cke), .sdram_cs_n (cs_n),
        .sdram_ras_n (ras_n), .sdram_cas_n (cas_n), .sdram_we_n (we_n),
        .sdram_ba (ba), .sdram_addr (addr)
    );

    sdram_init_seq u_dut_def (
        .sys_clk (sys_clk), .sys_rst (sys_rst2), .rst_ddr_n (rst_ddr_n2),
        .calc_done (done2), .sdram_cke (cke2), .sdram_cs_n (cs2),
        .sdram_ras_n (ras2), .sdram_cas_n (cas2), .sdram_we_n (we2),
        .sdram_ba (ba2), .sdram_addr (addr2)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    function automatic exp_t reset_exp();
        exp_t e;
        e = '{cke: 1'b0, cmd: C_INH, done: 1'b0, chk_pre: 1'b0, chk_lmr: 1'b0, chk_zero: 1'b1};
        return e;
    endfunction

    // Expected pins at offset 'off' cycles after the first CKE-high cycle
    function automatic exp_t timeline(input int off);
        exp_t e;
        int   lmr_at;
        lmr_at = TW + TRP + TR * TRFC;
        e = '{cke: 1'b1, cmd: C_NOP, done: 1'b0, chk_pre: 1'b0, chk_lmr: 1'b0, chk_zero: 1'b0};
        if (off == TW) begin
            e.cmd = C_PRE; e.chk_pre = 1'b1;
        end
        for (int k = 0; k < TR; k++)
            if (off == TW + TRP + k * TRFC) e.cmd = C_REF;
        if (off == lmr_at) begin
            e.cmd = C_LMR; e.chk_lmr = 1'b1;
        end
        if (off >= lmr_at + TMRD) e.done = 1'b1;
        return e;
    endfunction

    // Reference model: hold-off seen through a 2-edge delay, then a timeline
    always @(posedge sys_clk) begin
        exp_t e;
        if (sys_rst) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_run = 0;
            e = reset_exp();
        end else begin
            if (m_s2) m_run = m_run + 1;
            else      m_run = 0;
            m_s2 = m_s1;
            m_s1 = rst_ddr_n;
            if (m_run == 0) begin
                e = reset_exp();
                e.chk_zero = 1'b0;
            end else begin
                e = timeline(m_run - 1);
            end
        end
        exp_q.push_back(e);
    end

    // Monitor: pop one expectation per cycle and compare at the falling edge
    always @(negedge sys_clk) begin
        exp_t e;
        logic ok;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (sys_rst) e = reset_exp();
            ok = (cke === e.cke) && (cmd === e.cmd) && (calc_done === e.done);
            if (e.chk_pre)  ok = ok && (addr[10] === 1'b1);
            if (e.chk_lmr)  ok = ok && (ba === 2'b00) && (addr === TMODE);
            if (e.chk_zero) ok = ok && (ba === 2'b00) && (addr === 13'h0000);
            vectors = vectors + 1;
            if (!ok) begin
                miscompares = miscompares + 1;
                $display("FAIL pins t=%0t run=%0d: got cke=%b cmd=%b done=%b ba=%b addr=%h, want cke=%b cmd=%b done=%b",
                         $time, m_run, cke, cmd, calc_done, ba, addr, e.cke, e.cmd, e.done);
            end
        end
    end

    task automatic wait_done(input int budget, input string tag);
        int n;
        n = 0;
        while (calc_done !== 1'b1 && n < budget) begin
            @(posedge sys_clk); #2;
            n++;
        end
        vectors = vectors + 1;
        if (calc_done !== 1'b1) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: calc_done=%b after %0d cycles, want 1", tag, calc_done, budget);
        end
    endtask

    task automatic wait_run(input int target);
        int n;
        n = 0;
        while (m_run != target && n < 200) begin
            @(posedge sys_clk); #1;
            n++;
        end
        vectors = vectors + 1;
        if (m_run != target) begin
            miscompares = miscompares + 1;
            $display("FAIL reach_offset: run=%0d, want %0d", m_run, target);
        end
    endtask

    task automatic restart_pulse();
        @(posedge sys_clk); #2 rst_ddr_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #2 rst_ddr_n = 1'b1;
    endtask

    initial begin
        int cke_at, done_at, refs;
        vectors = 0; miscompares = 0;
        m_s1 = 1'b0; m_s2 = 1'b0; m_run = 0;
        sys_rst = 1'b1; rst_ddr_n = 1'b1;
        sys_rst2 = 1'b1; rst_ddr_n2 = 1'b1;

        // Reset held for 5 cycles with hold-off released, then clean init
        repeat (5) @(posedge sys_clk);
        #2 sys_rst = 1'b0;
        wait_done(100, "clean_init");
        repeat (5) @(posedge sys_clk);

        // Hold-off dropped mid-refresh for 4 cycles
        restart_pulse();
        wait_run(16);
        #1 rst_ddr_n = 1'b0;
        repeat (4) @(posedge sys_clk);
        #2 rst_ddr_n = 1'b1;
        wait_done(100, "reinit_after_midref_drop");

        // Hold-off dropped one cycle after calc_done
        @(posedge sys_clk); #2 rst_ddr_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #2 rst_ddr_n = 1'b1;
        wait_done(100, "reinit_after_done_drop");

        // Random hold-off pulses, occasionally with sys_rst also asserted
        for (int it = 0; it < 10; it++) begin
            repeat ($urandom_range(0, 40)) @(posedge sys_clk);
            #2 rst_ddr_n = 1'b0;
            if ($urandom_range(0, 3) == 0) sys_rst = 1'b1;
            repeat ($urandom_range(1, 5)) @(posedge sys_clk);
            #2 sys_rst = 1'b0;
            rst_ddr_n = 1'b1;
        end
        wait_done(100, "random_final");

        // Asynchronous sys_rst in the middle of a refresh wait
        restart_pulse();
        wait_run(16);
        #1 sys_rst = 1'b1;
        #1;
        vectors = vectors + 1;
        if (cke !== 1'b0 || cmd !== C_INH || calc_done !== 1'b0 || ba !== 2'b00 || addr !== 13'h0000) begin
            miscompares = miscompares + 1;
            $display("FAIL async_reset: cke=%b cmd=%b done=%b ba=%b addr=%h, want 0 1111 0 00 0000",
                     cke, cmd, calc_done, ba, addr);
        end
        repeat (2) @(posedge sys_clk);
        #2 sys_rst = 1'b0;
        wait_done(100, "init_after_async_reset");

        // Default parameters: full-length power-up
        @(posedge sys_clk); #2 sys_rst2 = 1'b0;
        cke_at = -1; done_at = -1; refs = 0;
        for (int i = 1; i <= 25000 && done_at < 0; i++) begin
            @(posedge sys_clk); #1;
            if (cke_at < 0 && cke2 === 1'b1) cke_at = i;
            if (cmd2 === C_REF) refs++;
            if (done2 === 1'b1) done_at = i;
        end
        vectors = vectors + 3;
        if (cke_at != 3) begin
            miscompares = miscompares + 1;
            $display("FAIL def_cke_rise: edge %0d, want 3", cke_at);
        end
        if (done_at < 0 || (done_at - cke_at) != 20060) begin
            miscompares = miscompares + 1;
            $display("FAIL def_done_offset: %0d, want 20060", (done_at < 0) ? -1 : done_at - cke_at);
        end
        if (refs != 8) begin
            miscompares = miscompares + 1;
            $display("FAIL def_refresh_count: %0d, want 8", refs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
